serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_if.sv | 45 ++++
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for the bit-serial adder controller:
// operand input channel, result output channel, flush and busy status.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  carry_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output carry_out,
    output busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one sum bit per clock through a single full-add cell,
// wrapped in an IDLE/RUN/DONE valid-ready controller with flush.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  // Full-add cell as two half-add stages.
  logic ha1_s;
  logic ha1_c;
  logic ha2_c;
  logic bit_s;
  logic c_next;

  always_comb begin
    ha1_s  = a_sh[0] ^ b_sh[0];
    ha1_c  = a_sh[0] & b_sh[0];
    bit_s  = ha1_s ^ carry;
    ha2_c  = ha1_s & carry;
    c_next = ha1_c | ha2_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            carry      <= bus.cin;
            cnt        <= '0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          sum_r[cnt] <= bit_s;
          carry      <= c_next;
          a_sh       <= a_sh >> 1;
          b_sh       <= b_sh >> 1;
          // Counter parks on LAST so it cannot wrap.
          if (cnt == LAST) begin
            cout_r      <= c_next;
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): driver pushes
// expected {carry_out,sum}, monitor pops on each accepted result.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [8:0] sb[$];

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-low-phase, pop on an accepted result.
  always @(negedge clk) begin
    #1;
    if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("sb_sum", {24'd0, bus.sum}, {24'd0, e[7:0]});
        check("sb_cout", {31'd0, bus.carry_out}, {31'd0, e[8]});
      end
    end
  end

  // Caller is at a negedge; returns at a negedge in IDLE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es,
                       input logic ec, input int hold,
                       input bit glitch);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_op", {31'd0, bus.in_ready}, 1);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    sb.push_back({ec, es});
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_after_accept", {31'd0, bus.busy}, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      check("in_ready_run", {31'd0, bus.in_ready}, 0);
      if (glitch && n == 3) begin
        bus.in_valid = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("latency", n, 8);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'd0, bus.out_valid}, 1);
      check("hold_sum", {24'd0, bus.sum}, {24'd0, es});
      check("hold_cout", {31'd0, bus.carry_out}, {31'd0, ec});
      check("hold_ready", {31'd0, bus.in_ready}, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_ready", {31'd0, bus.in_ready}, 1);
    check("idle_valid", {31'd0, bus.out_valid}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_sum", {24'd0, bus.sum}, 0);
    check("rst_cout", {31'd0, bus.carry_out}, 0);

    // First op accepted on the first edge with rst_n high.
    rst_n = 1'b1;
    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1, 1'b0);
    do_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 5, 1'b0);
    do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1, 1'b1);

    // Reset mid-RUN at counter 4.
    bus.a = 8'h55;
    bus.b = 8'h11;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", {31'd0, bus.in_ready}, 1);
    check("midrst_valid", {31'd0, bus.out_valid}, 0);
    check("midrst_sum", {24'd0, bus.sum}, 0);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, 1'b0);

    // Flush wins over out_ready in DONE.
    bus.a = 8'h33;
    bus.b = 8'h44;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_flush_valid", {31'd0, bus.out_valid}, 1);
    check("pre_flush_sum", {24'd0, bus.sum}, 32'h77);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("flush_valid", {31'd0, bus.out_valid}, 0);
    check("flush_sum", {24'd0, bus.sum}, 0);
    check("flush_ready", {31'd0, bus.in_ready}, 1);

    // Flush blocks acceptance in IDLE.
    bus.a = 8'hAA;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_busy", {31'd0, bus.busy}, 0);
    check("flush_idle_ready", {31'd0, bus.in_ready}, 1);
    @(negedge clk);
    check("flush_idle_stay", {31'd0, bus.busy}, 0);

    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    do_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
